// File: rtl/cmn_plru_entry_alloc.sv
// Single-client entry allocator: lowest free entry first, tree-PLRU victim when full.
// Tracks occupancy and recency through the touch, free and flush interfaces.
module cmn_plru_entry_alloc #(
    parameter int WIDTH = 8,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_vld,
    output logic              alloc_rdy,
    output logic [IDXW-1:0]   alloc_idx,
    output logic [WIDTH-1:0]  alloc_oh,
    output logic              alloc_evict,
    input  logic              touch_en,
    input  logic [WIDTH-1:0]  touch_oh,
    input  logic              free_en,
    input  logic [WIDTH-1:0]  free_oh,
    input  logic              flush,
    output logic [WIDTH-1:0]  valid_vec,
    output logic [IDXW:0]     valid_cnt,
    output logic              full,
    output logic              empty,
    output logic [WIDTH-2:0]  plru_node
);

    // Mark entry e as MRU: every ancestor points away from e's subtree.
    function automatic logic [WIDTH-2:0] plru_use(input logic [WIDTH-2:0] nodes,
                                                  input logic [IDXW-1:0]  e);
        logic [WIDTH-2:0] r;
        int n;
        int p;
        r = nodes;
        n = int'(e) + WIDTH - 1;
        for (int l = 0; l < IDXW; l++) begin
            p = (n - 1) / 2;
            for (int k = 0; k < WIDTH - 1; k++) begin
                if (k == p) begin
                    r[k] = n[0];
                end
            end
            n = p;
        end
        return r;
    endfunction

    function automatic logic [IDXW-1:0] plru_victim(input logic [WIDTH-2:0] nodes);
        int   n;
        logic b;
        n = 0;
        for (int l = 0; l < IDXW; l++) begin
            b = 1'b0;
            for (int k = 0; k < WIDTH - 1; k++) begin
                if (k == n) begin
                    b = nodes[k];
                end
            end
            n = 2 * n + (b ? 2 : 1);
        end
        return IDXW'(n - (WIDTH - 1));
    endfunction

    function automatic logic [IDXW-1:0] lowest_zero(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!v[k]) begin
                idx = k[IDXW-1:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [IDXW-1:0] encode(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            if (v[k]) begin
                idx = k[IDXW-1:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = {(IDXW+1){1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            c = c + {{IDXW{1'b0}}, v[k]};
        end
        return c;
    endfunction

    logic [WIDTH-1:0] valid_q, valid_d;
    logic [WIDTH-2:0] node_q, node_d;
    logic [IDXW:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    logic             fire_s;
    logic [IDXW-1:0]  idx_s;
    logic [WIDTH-1:0] oh_s;
    logic [WIDTH-1:0] touch_m_s;
    logic [WIDTH-1:0] free_m_s;
    logic [WIDTH-2:0] node_t_s;

    // Grant selection, touch-then-alloc PLRU update and occupancy next state.
    always_comb begin
        fire_s    = alloc_vld & ~flush;
        idx_s     = full_q ? plru_victim(node_q) : lowest_zero(valid_q);
        oh_s      = fire_s ? ({{(WIDTH-1){1'b0}}, 1'b1} << idx_s) : {WIDTH{1'b0}};
        touch_m_s = touch_en ? (touch_oh & valid_q) : {WIDTH{1'b0}};
        if (|touch_m_s) begin
            node_t_s = plru_use(node_q, encode(touch_m_s));
        end else begin
            node_t_s = node_q;
        end
        // Alloc wins over a same-cycle free of the granted entry.
        free_m_s = free_en ? (free_oh & valid_q & ~oh_s) : {WIDTH{1'b0}};
        if (flush) begin
            valid_d = {WIDTH{1'b0}};
            node_d  = {(WIDTH-1){1'b0}};
            cnt_d   = {(IDXW+1){1'b0}};
        end else begin
            valid_d = (valid_q & ~free_m_s) | oh_s;
            node_d  = fire_s ? plru_use(node_t_s, idx_s) : node_t_s;
            cnt_d   = cnt_q + {{IDXW{1'b0}}, (fire_s & ~full_q)} - popcount(free_m_s);
        end
        full_d  = (cnt_d == (IDXW+1)'(WIDTH));
        empty_d = (cnt_d == {(IDXW+1){1'b0}});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {WIDTH{1'b0}};
            node_q  <= {(WIDTH-1){1'b0}};
            cnt_q   <= {(IDXW+1){1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            node_q  <= node_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign alloc_rdy   = ~flush;
    assign alloc_idx   = idx_s;
    assign alloc_oh    = oh_s;
    assign alloc_evict = full_q;
    assign valid_vec   = valid_q;
    assign valid_cnt   = cnt_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign plru_node   = node_q;

endmodule

// File: tb/tb_cmn_plru_entry_alloc.sv
// Scoreboard bench for cmn_plru_entry_alloc at WIDTH=4: expectations are queued
// with each stimulus cycle and popped when the grant / registered state is sampled.
module tb_cmn_plru_entry_alloc;

    localparam int W  = 4;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_vld;
    logic          alloc_rdy;
    logic [IW-1:0] alloc_idx;
    logic [W-1:0]  alloc_oh;
    logic          alloc_evict;
    logic          touch_en;
    logic [W-1:0]  touch_oh;
    logic          free_en;
    logic [W-1:0]  free_oh;
    logic          flush;
    logic [W-1:0]  valid_vec;
    logic [IW:0]   valid_cnt;
    logic          full;
    logic          empty;
    logic [W-2:0]  plru_node;

    cmn_plru_entry_alloc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_idx(alloc_idx),
        .alloc_oh(alloc_oh), .alloc_evict(alloc_evict),
        .touch_en(touch_en), .touch_oh(touch_oh),
        .free_en(free_en), .free_oh(free_oh), .flush(flush),
        .valid_vec(valid_vec), .valid_cnt(valid_cnt), .full(full), .empty(empty),
        .plru_node(plru_node)
    );

    always #5 clk = ~clk;

    localparam int S_IDX = 0, S_OH = 1, S_EVICT = 2, S_RDY = 3, S_VALID = 4,
                   S_CNT = 5, S_FULL = 6, S_EMPTY = 7, S_PLRU = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q_now[$];
    exp_t q_post[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_IDX:   return 32'(alloc_idx);
            S_OH:    return 32'(alloc_oh);
            S_EVICT: return 32'(alloc_evict);
            S_RDY:   return 32'(alloc_rdy);
            S_VALID: return 32'(valid_vec);
            S_CNT:   return 32'(valid_cnt);
            S_FULL:  return 32'(full);
            S_EMPTY: return 32'(empty);
            S_PLRU:  return 32'(plru_node);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic exp_now(input string tag, input int sel, input logic [31:0] v);
        q_now.push_back('{tag, sel, v});
    endtask

    task automatic exp_post(input string tag, input int sel, input logic [31:0] v);
        q_post.push_back('{tag, sel, v});
    endtask

    task automatic exp_grant(input string tag, input int idx, input logic ev);
        exp_now({tag, "_idx"}, S_IDX, 32'(idx));
        exp_now({tag, "_oh"}, S_OH, 32'd1 << idx);
        exp_now({tag, "_evict"}, S_EVICT, 32'(ev));
    endtask

    // One clock cycle: drive, compare grant outputs, clock, compare registered state.
    task automatic step(input logic av, input logic ten, input logic [W-1:0] toh,
                        input logic fen, input logic [W-1:0] foh, input logic fl);
        exp_t e;
        @(negedge clk);
        alloc_vld = av; touch_en = ten; touch_oh = toh;
        free_en = fen; free_oh = foh; flush = fl;
        #1;
        while (q_now.size() > 0) begin
            e = q_now.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
        @(posedge clk);
        #1;
        alloc_vld = 1'b0; touch_en = 1'b0; touch_oh = 4'b0000;
        free_en = 1'b0; free_oh = 4'b0000; flush = 1'b0; rst = 1'b0;
        while (q_post.size() > 0) begin
            e = q_post.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic do_alloc();
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic do_touch(input int e);
        step(1'b0, 1'b1, 4'b0001 << e, 1'b0, 4'b0000, 1'b0);
    endtask

    always @(posedge clk) begin
        if (!rst && touch_en) begin
            assert ($onehot0(touch_oh)) else $error("touch_oh not one-hot: %b", touch_oh);
        end
        assert (valid_cnt <= (IW+1)'(W)) else $error("valid_cnt out of range: %0d", valid_cnt);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] fill_plru [4];
        fill_plru[0] = 3'b011; fill_plru[1] = 3'b001;
        fill_plru[2] = 3'b100; fill_plru[3] = 3'b000;

        rst = 1'b1; alloc_vld = 1'b0; touch_en = 1'b0; touch_oh = 4'b0000;
        free_en = 1'b0; free_oh = 4'b0000; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        exp_now("rst_rdy", S_RDY, 32'd1);
        exp_now("rst_oh", S_OH, 32'd0);
        exp_post("rst_valid", S_VALID, 32'd0);
        exp_post("rst_plru", S_PLRU, 32'd0);
        exp_post("rst_cnt", S_CNT, 32'd0);
        exp_post("rst_empty", S_EMPTY, 32'd1);
        exp_post("rst_full", S_FULL, 32'd0);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Back-to-back fill.
        for (int i = 0; i < 4; i++) begin
            exp_grant("fill", i, 1'b0);
            exp_post("fill_plru", S_PLRU, 32'(fill_plru[i]));
            exp_post("fill_cnt", S_CNT, 32'(i + 1));
            do_alloc();
        end
        exp_now("fill_full", S_FULL, 32'd1);
        exp_now("fill_valid", S_VALID, 32'hf);
        exp_now("fill_empty", S_EMPTY, 32'd0);

        // Evictions from the full state.
        exp_grant("ev0", 0, 1'b1);
        exp_post("ev0_plru", S_PLRU, 32'h3);
        exp_post("ev0_cnt", S_CNT, 32'd4);
        do_alloc();
        exp_grant("ev1", 2, 1'b1);
        exp_post("ev1_plru", S_PLRU, 32'h6);
        exp_post("ev1_cnt", S_CNT, 32'd4);
        do_alloc();

        // Bring nodes back to 000 via touches.
        exp_post("t1_plru", S_PLRU, 32'h5);
        do_touch(1);
        exp_post("t3_plru", S_PLRU, 32'h0);
        do_touch(3);

        // Touch 0 then 2, then alloc picks entry 1.
        exp_post("t0_plru", S_PLRU, 32'h3);
        do_touch(0);
        exp_post("t2_plru", S_PLRU, 32'h6);
        do_touch(2);
        exp_grant("tv", 1, 1'b1);
        exp_post("tv_plru", S_PLRU, 32'h5);
        do_alloc();

        // Free entry 1 while full, then refill it without eviction.
        exp_post("fr_cnt", S_CNT, 32'd3);
        exp_post("fr_valid", S_VALID, 32'hd);
        exp_post("fr_plru", S_PLRU, 32'h5);
        exp_post("fr_full", S_FULL, 32'd0);
        step(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0);
        exp_grant("ra", 1, 1'b0);
        exp_post("ra_cnt", S_CNT, 32'd4);
        exp_post("ra_plru", S_PLRU, 32'h5);
        do_alloc();

        // Same-cycle alloc (victim 0), free of entry 0 and touch of entry 3.
        exp_post("s1_plru", S_PLRU, 32'h5);
        do_touch(1);
        exp_post("s3_plru", S_PLRU, 32'h0);
        do_touch(3);
        exp_grant("mix", 0, 1'b1);
        exp_post("mix_valid", S_VALID, 32'hf);
        exp_post("mix_cnt", S_CNT, 32'd4);
        exp_post("mix_plru", S_PLRU, 32'h3);
        step(1'b1, 1'b1, 4'b1000, 1'b1, 4'b0001, 1'b0);

        // Flush wins over alloc and touch.
        exp_now("fl_rdy", S_RDY, 32'd0);
        exp_now("fl_oh", S_OH, 32'd0);
        exp_post("fl_valid", S_VALID, 32'd0);
        exp_post("fl_plru", S_PLRU, 32'd0);
        exp_post("fl_cnt", S_CNT, 32'd0);
        exp_post("fl_empty", S_EMPTY, 32'd1);
        step(1'b1, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1);
        exp_grant("pf", 0, 1'b0);
        exp_post("pf_cnt", S_CNT, 32'd1);
        exp_post("pf_plru", S_PLRU, 32'h3);
        do_alloc();

        // Touching or freeing invalid entries changes nothing.
        exp_post("ti_plru", S_PLRU, 32'h3);
        do_touch(2);
        exp_post("fi_cnt", S_CNT, 32'd1);
        exp_post("fi_valid", S_VALID, 32'h1);
        step(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0);
        exp_grant("a1", 1, 1'b0);
        exp_post("a1_valid", S_VALID, 32'h3);
        exp_post("a1_plru", S_PLRU, 32'h1);
        exp_post("a1_cnt", S_CNT, 32'd2);
        do_alloc();

        // Reset mid-operation drops the request.
        rst = 1'b1;
        exp_post("mr_valid", S_VALID, 32'd0);
        exp_post("mr_cnt", S_CNT, 32'd0);
        exp_post("mr_plru", S_PLRU, 32'd0);
        exp_post("mr_empty", S_EMPTY, 32'd1);
        do_alloc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
